// File: rtl/imem_loader.sv
// Boot-time loader: parses a LEN_HI/LEN_LO/payload/CSUM byte stream and writes the payload
// into a byte-addressed, big-endian instruction memory while holding the CPU in reset.
module imem_loader #(
    parameter int MEM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       last_word
);

    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [15:0]      MAX_LEN = 16'(MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [31:0]        r_last_word;
    logic [7:0]         r_len_hi;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_xor;
    logic [23:0]        r_asm;

    logic               w_xfer;
    logic [15:0]        w_len;
    logic               w_len_bad;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_xfer    = in_valid & r_in_ready;
    assign w_len     = {r_len_hi, in_byte};
    assign w_len_bad = (w_len > MAX_LEN) || (w_len[1:0] != 2'b00);
    assign w_cnt_nxt = r_cnt + CNT_ONE;

    // Frame-parsing FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_last_word <= 32'h0000_0000;
            r_len_hi    <= 8'h00;
            r_len       <= '0;
            r_cnt       <= '0;
            r_xor       <= 8'h00;
            r_asm       <= 24'h00_0000;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state     <= S_LEN_HI;
                        r_in_ready  <= 1'b1;
                        r_cpu_hold  <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_last_word <= 32'h0000_0000;
                        r_cnt       <= '0;
                        r_xor       <= 8'h00;
                        r_asm       <= 24'h00_0000;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= in_byte;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len[CNT_W-1:0];
                        if (w_len_bad) begin
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[ADDR_W-1:0];
                        r_wr_data <= in_byte;
                        r_xor     <= r_xor ^ in_byte;
                        r_asm     <= {r_asm[15:0], in_byte};
                        r_cnt     <= w_cnt_nxt;
                        // The fourth byte of a word completes it: publish with its write.
                        if (r_cnt[1:0] == 2'b11) begin
                            r_last_word <= {r_asm, in_byte};
                        end
                        if (w_cnt_nxt == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (in_byte == r_xor) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_ERROR;
                    r_in_ready <= 1'b0;
                    r_cpu_hold <= 1'b1;
                    r_done     <= 1'b0;
                    r_error    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;
    assign last_word = r_last_word;

endmodule
